// File: rtl/td4_pkg.sv
// Shared definitions for the TD4-style fetch front end: default widths,
// fetch state encoding and the jump opcodes decode feeds back on.
package td4_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam logic [3:0] JMP = 4'b1111;
    localparam logic [3:0] JNC = 4'b1110;

endpackage

// File: rtl/prog_rom.sv
// Program memory: 2^ADDR_W words, synchronous write and synchronous read.
// Only the read register is cleared; the array contents survive reset.
module prog_rom
    import td4_pkg::*;
#(
    parameter int ADDR_W = td4_pkg::ADDR_W,
    parameter int DATA_W = td4_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rd_clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the instruction register seen by decode.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/ISSUE sequencer around a program memory,
// presenting one instruction per two cycles to decode with jump feedback.
module fetch_unit
    import td4_pkg::*;
#(
    parameter int ADDR_W = td4_pkg::ADDR_W,
    parameter int DATA_W = td4_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              jump_en,
    input  logic              jump_nc,
    input  logic              carry,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              running
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              handshake;
    logic              take_jump;
    logic              rd_en;
    logic              wr_en;

    assign inst_valid = (state == ISSUE);
    assign running    = (state != IDLE);
    assign handshake  = inst_valid & inst_ready;
    assign take_jump  = jump_en & (~jump_nc | ~carry);
    assign wr_en      = rst & prog_we & (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Jump feedback only matters in the handshake cycle; halt wins over start.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !halt_req) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (halt_req) begin
                    state_nxt = IDLE;
                end else begin
                    rd_en     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    pc_nxt    = take_jump ? jump_addr : pc + ADDR_W'(1);
                    state_nxt = halt_req ? IDLE : FETCH;
                end else if (halt_req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    prog_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_prog_rom (
        .clk     (clk),
        .rd_clr  (~rst),
        .we      (wr_en),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .re      (rd_en),
        .rd_addr (pc),
        .rd_data (inst)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; the bench plays the decode
// stage and drives jump feedback from its own hand-written instruction tables.
module tb_fetch_unit;
    import td4_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       halt_req;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] inst;
    logic       inst_valid;
    logic       inst_ready;
    logic       jump_en;
    logic       jump_nc;
    logic       carry;
    logic [3:0] jump_addr;
    logic [3:0] pc;
    logic       running;

    int tests_run    = 0;
    int tests_failed = 0;

    fetch_unit #(
        .ADDR_W (4),
        .DATA_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt_req   (halt_req),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .jump_en    (jump_en),
        .jump_nc    (jump_nc),
        .carry      (carry),
        .jump_addr  (jump_addr),
        .pc         (pc),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start      = 1'b0;
        halt_req   = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        inst_ready = 1'b0;
        jump_en    = 1'b0;
        jump_nc    = 1'b0;
        carry      = 1'b0;
        jump_addr  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        tests_run++;
        if (pc !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_pc: got %0d want 0", pc);
        end
        tests_run++;
        if (inst !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_inst: got %h want 00", inst);
        end
        tests_run++;
        if ({inst_valid, running} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got valid=%b running=%b want 0 0", inst_valid, running);
        end
        rst = 1'b1;
    endtask

    // Straight-line program ending in JMP 0, ready held high throughout.
    task automatic test_sequence();
        logic [7:0] exp_inst [4];
        logic [3:0] exp_pc   [4];
        exp_inst = '{8'h30, 8'h51, 8'hF0, 8'h30};
        exp_pc   = '{4'd0, 4'd1, 4'd2, 4'd0};
        do_reset();
        prog_write(4'd0, 8'h30);
        prog_write(4'd1, 8'h51);
        prog_write(4'd2, {JMP, 4'h0});
        inst_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({running, inst_valid, pc} !== {1'b1, 1'b0, 4'd0}) begin
            tests_failed++;
            $display("[TB] FAIL seq_fetch0: got running=%b valid=%b pc=%0d want 1 0 0", running, inst_valid, pc);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if ({inst_valid, inst, pc} !== {1'b1, exp_inst[k], exp_pc[k]}) begin
                tests_failed++;
                $display("[TB] FAIL seq_issue%0d: got valid=%b inst=%h pc=%0d want 1 %h %0d",
                         k, inst_valid, inst, pc, exp_inst[k], exp_pc[k]);
            end
            jump_en   = (exp_inst[k][7:4] == JMP);
            jump_addr = exp_inst[k][3:0];
            tick();
            jump_en = 1'b0;
            tests_run++;
            if ({inst_valid, running} !== 2'b01) begin
                tests_failed++;
                $display("[TB] FAIL seq_gap%0d: got valid=%b running=%b want 0 1", k, inst_valid, running);
            end
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tests_run++;
        if ({running, inst_valid, pc} !== {1'b0, 1'b0, 4'd1}) begin
            tests_failed++;
            $display("[TB] FAIL seq_halt_fetch: got running=%b valid=%b pc=%0d want 0 0 1", running, inst_valid, pc);
        end
    endtask

    // JNC 5 at address 3: taken only when carry is clear.
    task automatic test_jnc();
        logic       carry_v;
        logic [3:0] exp_pc;
        do_reset();
        prog_write(4'd0, {JMP, 4'd3});
        prog_write(4'd3, {JNC, 4'd5});
        for (int c = 0; c < 2; c++) begin
            carry_v = (c == 0);
            exp_pc  = carry_v ? 4'd4 : 4'd5;
            do_reset();
            inst_ready = 1'b1;
            start      = 1'b1;
            tick();
            start = 1'b0;
            tick();
            jump_en   = 1'b1;
            jump_addr = 4'd3;
            tick();
            jump_en = 1'b0;
            tick();
            tests_run++;
            if ({inst_valid, inst, pc} !== {1'b1, 8'hE5, 4'd3}) begin
                tests_failed++;
                $display("[TB] FAIL jnc_issue_c%0d: got valid=%b inst=%h pc=%0d want 1 e5 3", carry_v, inst_valid, inst, pc);
            end
            jump_en   = 1'b1;
            jump_nc   = 1'b1;
            carry     = carry_v;
            jump_addr = 4'd5;
            tick();
            clear_inputs();
            tests_run++;
            if (pc !== exp_pc) begin
                tests_failed++;
                $display("[TB] FAIL jnc_target_c%0d: got pc=%0d want %0d", carry_v, pc, exp_pc);
            end
            halt_req = 1'b1;
            tick();
            halt_req = 1'b0;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        prog_write(4'd0, {JMP, 4'hF});
        prog_write(4'd15, 8'h42);
        inst_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        jump_en   = 1'b1;
        jump_addr = 4'hF;
        tick();
        jump_en = 1'b0;
        tick();
        tests_run++;
        if ({inst_valid, inst, pc} !== {1'b1, 8'h42, 4'd15}) begin
            tests_failed++;
            $display("[TB] FAIL wrap_issue15: got valid=%b inst=%h pc=%0d want 1 42 15", inst_valid, inst, pc);
        end
        tick();
        tests_run++;
        if ({running, inst_valid, pc} !== {1'b1, 1'b0, 4'd0}) begin
            tests_failed++;
            $display("[TB] FAIL wrap_pc: got running=%b valid=%b pc=%0d want 1 0 0", running, inst_valid, pc);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
    endtask

    // Decode stalls for several cycles while noisy jump feedback is present.
    task automatic test_stall();
        do_reset();
        prog_write(4'd0, 8'h30);
        start = 1'b1;
        tick();
        start     = 1'b0;
        jump_en   = 1'b1;
        jump_addr = 4'd9;
        tick();
        tests_run++;
        if ({inst_valid, inst, pc} !== {1'b1, 8'h30, 4'd0}) begin
            tests_failed++;
            $display("[TB] FAIL stall_first: got valid=%b inst=%h pc=%0d want 1 30 0", inst_valid, inst, pc);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({inst_valid, inst, pc} !== {1'b1, 8'h30, 4'd0}) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold%0d: got valid=%b inst=%h pc=%0d want 1 30 0", i, inst_valid, inst, pc);
            end
        end
        jump_en    = 1'b0;
        inst_ready = 1'b1;
        tick();
        tests_run++;
        if ({inst_valid, pc} !== {1'b0, 4'd1}) begin
            tests_failed++;
            $display("[TB] FAIL stall_release: got valid=%b pc=%0d want 0 1", inst_valid, pc);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
    endtask

    task automatic test_halt_issue();
        do_reset();
        prog_write(4'd0, {JMP, 4'd3});
        prog_write(4'd3, 8'h77);
        inst_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        jump_en   = 1'b1;
        jump_addr = 4'd3;
        tick();
        jump_en    = 1'b0;
        inst_ready = 1'b0;
        tick();
        tests_run++;
        if ({inst_valid, inst, pc} !== {1'b1, 8'h77, 4'd3}) begin
            tests_failed++;
            $display("[TB] FAIL halt_pre: got valid=%b inst=%h pc=%0d want 1 77 3", inst_valid, inst, pc);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tests_run++;
        if ({running, inst_valid, pc} !== {1'b0, 1'b0, 4'd3}) begin
            tests_failed++;
            $display("[TB] FAIL halt_issue: got running=%b valid=%b pc=%0d want 0 0 3", running, inst_valid, pc);
        end
        prog_we   = 1'b1;
        prog_addr = 4'd3;
        prog_data = 8'hA5;
        start     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        tick();
        tests_run++;
        if ({inst_valid, inst, pc} !== {1'b1, 8'hA5, 4'd3}) begin
            tests_failed++;
            $display("[TB] FAIL halt_rewrite: got valid=%b inst=%h pc=%0d want 1 a5 3", inst_valid, inst, pc);
        end
        inst_ready = 1'b1;
        halt_req   = 1'b1;
        tick();
        inst_ready = 1'b0;
        tests_run++;
        if ({running, pc} !== {1'b0, 4'd4}) begin
            tests_failed++;
            $display("[TB] FAIL halt_handshake: got running=%b pc=%0d want 0 4", running, pc);
        end
        start = 1'b1;
        tick();
        tick();
        tests_run++;
        if (running !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL halt_start_idle: got running=%b want 0", running);
        end
        clear_inputs();
    endtask

    // Reset lands mid-handshake; stray writes outside IDLE must not stick.
    task automatic test_reset_issue();
        do_reset();
        prog_write(4'd0, {JMP, 4'd7});
        prog_write(4'd7, 8'h9C);
        inst_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        jump_en   = 1'b1;
        jump_addr = 4'd7;
        tick();
        jump_en    = 1'b0;
        inst_ready = 1'b0;
        prog_we    = 1'b1;
        prog_addr  = 4'd7;
        prog_data  = 8'h11;
        tick();
        tests_run++;
        if ({inst_valid, inst, pc} !== {1'b1, 8'h9C, 4'd7}) begin
            tests_failed++;
            $display("[TB] FAIL rstiss_pre: got valid=%b inst=%h pc=%0d want 1 9c 7", inst_valid, inst, pc);
        end
        inst_ready = 1'b1;
        rst        = 1'b0;
        tick();
        rst     = 1'b1;
        prog_we = 1'b0;
        tests_run++;
        if ({running, inst_valid, pc, inst} !== {1'b0, 1'b0, 4'd0, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL rstiss_state: got running=%b valid=%b pc=%0d inst=%h want 0 0 0 00",
                     running, inst_valid, pc, inst);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tests_run++;
        if ({inst_valid, inst, pc} !== {1'b1, 8'hF7, 4'd0}) begin
            tests_failed++;
            $display("[TB] FAIL rstiss_mem0: got valid=%b inst=%h pc=%0d want 1 f7 0", inst_valid, inst, pc);
        end
        jump_en   = 1'b1;
        jump_addr = 4'd7;
        tick();
        jump_en = 1'b0;
        tick();
        tests_run++;
        if ({inst_valid, inst, pc} !== {1'b1, 8'h9C, 4'd7}) begin
            tests_failed++;
            $display("[TB] FAIL rstiss_mem7: got valid=%b inst=%h pc=%0d want 1 9c 7", inst_valid, inst, pc);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_sequence();
        test_jnc();
        test_wrap();
        test_stall();
        test_halt_issue();
        test_reset_issue();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
